i2s_tx_serializer: RTL and testbench

Stereo I2S transmitter in the 50 MHz system domain. It sits directly downstream of the sample source (ROM address sequencer or DMA reader) and upstream of the codec's DIN pin. It buffers left/right sample pairs in a small FIFO and serializes them MSB-first. The serial bit clock and word clock come from the codec, which is I2S master. Both are oversampled and edge-detected, so no logic is clocked by an external pin.

---
 rtl/mp3_audio_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 49 ++++
 rtl/i2s_tx_serializer.sv | 127 ++++++++++++
 tb/tb_i2s_tx_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_audio_pkg.sv
// Shared audio types for the sample path: default widths, the stereo pair
// record carried through the transmit FIFO, and slot alignment.
package mp3_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_sample_t;

    // Left-justify a sample in its slot; the unused LSBs go out as zeros.
    function automatic logic [SLOT_W-1:0] slot_align(input logic [SAMPLE_W-1:0] s);
        logic [SLOT_W-1:0] v;
        v = '0;
        v[SLOT_W-1 -: SAMPLE_W] = s;
        return v;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO of stereo pairs. Pointers carry one extra
// wrap bit so full and empty come straight from registered state.
module sample_fifo
    import mp3_audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           push,
    input  stereo_sample_t din,
    input  logic           pop,
    output stereo_sample_t dout,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);

    stereo_sample_t mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter, codec is bit/word clock master. SCLK and LRCLK are
// oversampled in the system domain; all serializer state moves on SCLK falls.
module i2s_tx_serializer
    import mp3_audio_pkg::*;
#(
    parameter int SAMPLE_W   = mp3_audio_pkg::SAMPLE_W,
    parameter int SLOT_W     = mp3_audio_pkg::SLOT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                sclk_in,
    input  logic                lrclk_in,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                sdout,
    output logic                active,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    // [0],[1] synchronize, [2] is the sclk history for edge detect
    logic [2:0]        sclk_pipe;
    logic [1:0]        lr_pipe;
    logic              fall;
    logic              lr_now;
    logic              lr_prev;
    logic              boundary;
    logic              left_b;
    logic              load_en;

    stereo_sample_t    hold;
    stereo_sample_t    hold_nx;
    stereo_sample_t    fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              fifo_push;

    logic [SLOT_W-1:0] shreg;
    logic [SLOT_W-1:0] load_val;
    logic [15:0]       underrun_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_pipe <= '0;
            lr_pipe   <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], sclk_in};
            lr_pipe   <= {lr_pipe[0], lrclk_in};
        end
    end

    assign fall     = sclk_pipe[2] && !sclk_pipe[1];
    assign lr_now   = lr_pipe[1];
    assign boundary = fall && (lr_now != lr_prev);
    assign left_b   = boundary && !lr_now;

    assign sample_ready = !fifo_full;
    assign fifo_push    = sample_valid && !fifo_full;
    assign fifo_pop     = left_b && !fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .din   ('{l: sample_l, r: sample_r}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Left boundary refreshes hold; the left slot loads from the fresh value
    always_comb begin
        hold_nx  = hold;
        load_val = '0;
        if (left_b)
            hold_nx = fifo_empty ? '0 : fifo_dout;
        if (!mute)
            load_val = left_b ? slot_align(hold_nx.l) : slot_align(hold.r);
    end

    assign load_en = boundary && (active || left_b);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lr_prev        <= 1'b1;
            active         <= 1'b0;
            hold           <= '0;
            shreg          <= '0;
            sdout          <= 1'b0;
            underrun       <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun <= 1'b0;
            if (fall) begin
                lr_prev <= lr_now;
                if (left_b) begin
                    hold   <= hold_nx;
                    active <= 1'b1;
                    if (active && fifo_empty) begin
                        underrun <= 1'b1;
                        if (underrun_cnt_q != 16'hFFFF)
                            underrun_cnt_q <= underrun_cnt_q + 16'd1;
                    end
                end
                if (boundary) begin
                    sdout <= 1'b0;
                    if (load_en)
                        shreg <= load_val;
                end else if (active) begin
                    sdout <= shreg[SLOT_W-1];
                    shreg <= shreg << 1;
                end
            end
        end
    end

    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a codec-style SCLK/LRCLK driver,
// slot capture, and a table of frames with hand-computed bit patterns.
module tb_i2s_tx_serializer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sclk_in;
    logic        lrclk_in;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        mute;
    logic        sdout;
    logic        active;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;
    int urun_seen = 0;

    i2s_tx_serializer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sclk_in      (sclk_in),
        .lrclk_in     (lrclk_in),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .sdout        (sdout),
        .active       (active),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 Clk = ~Clk;

    // Counts Clk cycles with underrun high, so a stretched pulse shows up
    always @(negedge Clk) if (underrun) urun_seen++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    typedef struct {
        logic        mute;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        int          exp_ur;
    } frame_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One SCLK period: high half, then fall with the new LRCLK, sample late in the low half
    task automatic bit_clk(input logic lr, output logic sd);
        @(negedge Clk) sclk_in = 1'b1;
        repeat (8) @(negedge Clk);
        sclk_in  = 1'b0;
        lrclk_in = lr;
        repeat (8) @(negedge Clk);
        sd = sdout;
    endtask

    task automatic run_bits(input logic lr, input int n, output logic [31:0] bits);
        logic b;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            bit_clk(lr, b);
            bits = {bits[30:0], b};
        end
    endtask

    task automatic run_frame(output logic [31:0] lb, output logic [31:0] rb, output int nur);
        int u0;
        u0 = urun_seen;
        run_bits(1'b0, 32, lb);
        run_bits(1'b1, 32, rb);
        nur = urun_seen - u0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        @(negedge Clk);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        @(negedge Clk);
        sample_valid = 1'b0;
    endtask

    function automatic logic [31:0] slot(input logic [15:0] s);
        return {1'b0, s, 15'd0};
    endfunction

    pair_t       bp_pairs [5];
    frame_t      frames   [5];
    logic [31:0] lb, rb;
    int          nur;

    initial begin
        bp_pairs[0] = '{16'h1234, 16'h8001};
        bp_pairs[1] = '{16'hFFFF, 16'h7FFF};
        bp_pairs[2] = '{16'h0001, 16'h8000};
        bp_pairs[3] = '{16'h5A5A, 16'hC3C3};
        bp_pairs[4] = '{16'hDEAD, 16'hBEEF};
        frames[0] = '{1'b0, slot(16'h1234), slot(16'h8001), 0};
        frames[1] = '{1'b1, 32'd0,          32'd0,          0};
        frames[2] = '{1'b0, slot(16'h0001), slot(16'h8000), 0};
        frames[3] = '{1'b0, slot(16'h5A5A), slot(16'hC3C3), 0};
        frames[4] = '{1'b0, 32'd0,          32'd0,          1};

        Reset = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b1;
        sample_l = '0; sample_r = '0; sample_valid = 1'b0; mute = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_sdout",    {31'd0, sdout},        32'd0);
        chk("rst_ready",    {31'd0, sample_ready}, 32'd1);
        chk("rst_active",   {31'd0, active},       32'd0);
        chk("rst_underrun", {31'd0, underrun},     32'd0);
        chk("rst_cnt",      {16'd0, underrun_cnt}, 32'd0);
        Reset = 1'b0;

        // Push before lock, then idle right-slot falls must not lock
        push(16'hA5C3, 16'h0F0F);
        run_bits(1'b1, 3, lb);
        chk("prelock_sdout",  lb, 32'd0);
        chk("prelock_active", {31'd0, active}, 32'd0);

        run_frame(lb, rb, nur);
        chk("basic_left",   lb, slot(16'hA5C3));
        chk("basic_right",  rb, slot(16'h0F0F));
        chk("basic_ur",     nur, 0);
        chk("basic_active", {31'd0, active}, 32'd1);

        for (int f = 0; f < 3; f++) begin
            run_frame(lb, rb, nur);
            chk("urun_left",  lb, 32'd0);
            chk("urun_right", rb, 32'd0);
            chk("urun_pulse", nur, 1);
        end
        chk("urun_cnt", {16'd0, underrun_cnt}, 32'd3);

        // Backpressure with SCLK stopped: four accepted, fifth refused
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_ready", {31'd0, sample_ready}, (i < 4) ? 32'd1 : 32'd0);
            sample_l     = bp_pairs[i].l;
            sample_r     = bp_pairs[i].r;
            sample_valid = 1'b1;
        end
        @(negedge Clk);
        chk("bp_ready_full", {31'd0, sample_ready}, 32'd0);
        sample_valid = 1'b0;

        for (int f = 0; f < 5; f++) begin
            mute = frames[f].mute;
            run_frame(lb, rb, nur);
            mute = 1'b0;
            chk($sformatf("tbl%0d_left", f),  lb,  frames[f].exp_l);
            chk($sformatf("tbl%0d_right", f), rb,  frames[f].exp_r);
            chk($sformatf("tbl%0d_ur", f),    nur, frames[f].exp_ur);
        end
        chk("tbl_cnt",   {16'd0, underrun_cnt}, 32'd4);
        chk("tbl_ready", {31'd0, sample_ready}, 32'd1);

        // Reset at bit 7 of a left slot
        push(16'hFFFF, 16'hFFFF);
        run_bits(1'b0, 8, lb);
        chk("mid_bits", lb, 32'h0000_007F);
        @(negedge Clk) Reset = 1'b1;
        #1;
        chk("mid_rst_sdout",  {31'd0, sdout},        32'd0);
        chk("mid_rst_active", {31'd0, active},       32'd0);
        chk("mid_rst_cnt",    {16'd0, underrun_cnt}, 32'd0);
        chk("mid_rst_ready",  {31'd0, sample_ready}, 32'd1);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        nur = urun_seen;
        run_bits(1'b0, 24, lb);
        chk("post_rst_left",   lb, 32'd0);
        chk("post_rst_active", {31'd0, active}, 32'd1);
        run_bits(1'b1, 32, rb);
        chk("post_rst_right",  rb, 32'd0);
        chk("post_rst_ur",     urun_seen - nur, 0);
        chk("post_rst_cnt",    {16'd0, underrun_cnt}, 32'd0);
        push(16'h8421, 16'h1248);
        run_frame(lb, rb, nur);
        chk("relock_left",  lb, slot(16'h8421));
        chk("relock_right", rb, slot(16'h1248));
        chk("relock_ur",    nur, 0);

        // Saturation: preload near the top, then underrun twice
        @(negedge Clk) force dut.underrun_cnt_q = 16'hFFFE;
        @(negedge Clk) release dut.underrun_cnt_q;
        run_frame(lb, rb, nur);
        chk("sat_cnt1", {16'd0, underrun_cnt}, 32'h0000_FFFF);
        chk("sat_ur1",  nur, 1);
        run_frame(lb, rb, nur);
        chk("sat_cnt2", {16'd0, underrun_cnt}, 32'h0000_FFFF);
        chk("sat_ur2",  nur, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
